control_fsm: RTL and testbench
==============================

# control_fsm

Parametrised multi-cycle instruction controller for the RISC microcontroller datapath. It accepts one decoded instruction at a time, sequences it through decode, optional multi-cycle execute or memory wait, and write-back, and issues the register-file write enable, PC advance and unit handshakes. Unlike the previous single-flop write-enable generator, it stalls on long operations (MUL/DIV, LOAD/STORE), masks write-back per opcode, detects illegal opcodes and execute-unit timeouts, and supports HALT.

## Interface
- OPW, 4, opcode width
- RAW, 3, destination register address width
- NOWB_MASK, 16'h8E00, bit i = 1 means opcode i never writes back (STORE, JMP, BEQ, HALT)
- MULTI_MASK, 16'h000C, bit i = 1 means opcode i uses the execute handshake (MUL, DIV)
- ILLEGAL_MASK, 16'h7000, bit i = 1 means opcode i is reserved (0xC-0xE)
- MAX_WAIT, 255, execute-wait timeout in cycles (>= 2)
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  fetch stage presents an instruction
- instr_ready  out  1  controller can accept an instruction
- opcode  in  OPW  opcode, sampled on accept
- rd  in  RAW  destination register, sampled on accept
- ex_start  out  1  one-cycle start pulse to MUL/DIV unit
- ex_done  in  1  MUL/DIV result ready
- mem_req  out  1  memory request, held until acknowledged
- mem_ack  in  1  memory acknowledge
- write_enable  out  1  register-file write strobe
- wb_addr  out  RAW  register-file write address
- pc_en  out  1  PC advance strobe
- halted  out  1  HALT executed (sticky)
- err  out  1  illegal opcode or execute timeout (sticky)

## Operation
- States: FETCH, DECODE, WAIT_EX, WAIT_MEM, WB, HALT, ERR. Reset state FETCH.
- All outputs are Moore functions of the state register and latched opcode/rd; reset values: instr_ready=1 (FETCH), all others 0, wb_addr=0.
- FETCH: instr_ready=1. instr_valid=1 latches opcode/rd, go DECODE; else stay.
- DECODE (1 cycle): ILLEGAL_MASK hit -> ERR; opcode 0xF -> HALT; MULTI_MASK hit -> ex_start=1, go WAIT_EX; opcode 0x8/0x9 (LOAD/STORE) -> go WAIT_MEM; otherwise -> WB. Priority in that order.
- WAIT_EX: timer cleared on entry, increments each cycle. ex_done=1 -> WB. Else timer == MAX_WAIT-1 -> ERR. ex_done wins over timeout in the same cycle. ex_done during DECODE is ignored.
- WAIT_MEM: mem_req=1 every cycle; mem_ack=1 -> WB. No timeout. mem_ack outside WAIT_MEM ignored.
- WB (1 cycle): pc_en=1; write_enable=1 unless NOWB_MASK bit set; wb_addr = latched rd. Then FETCH.
- HALT: halted=1, instr_ready=0, no strobes; exits only on reset.
- ERR: err=1, instr_ready=0, no strobes; exits only on reset.
- reset_n low in any state: immediate return to FETCH with reset values; pending handshakes abandoned, no write_enable/pc_en emitted.

## Timing
- Simple ALU op accepted at cycle N: DECODE N+1, WB (write_enable, pc_en) N+2, instr_ready N+3. Throughput one instruction per 3 cycles.
- MUL/DIV: ex_start at N+1; ex_done seen at cycle M gives WB at M+1.
- LOAD/STORE: mem_req from N+2 until mem_ack cycle M; WB at M+1.
- Timeout: ERR entered MAX_WAIT cycles after entering WAIT_EX when ex_done never asserts.

## Structure
- Shared package ctrl_pkg: opcode constants (ADD..HALT), state enum, default mask constants.
- Sub-module wait_timer: clear/enable counter, width $clog2(MAX_WAIT), expire flag.

## Test plan
- Reset, ADD (0x0) rd=5 -> write_enable=1, wb_addr=5, pc_en=1 exactly at cycle N+2; instr_ready back at N+3.
- STORE (0x9), mem_ack after 4 cycles -> mem_req high 4 cycles then 1 cycle with ack, WB with write_enable=0, pc_en=1.
- DIV (0x3) rd=2, ex_done 10 cycles after ex_start -> single ex_start pulse, write_enable=1 wb_addr=2 the cycle after ex_done.
- MUL with MAX_WAIT=8, ex_done never -> err=1 after 8 WAIT_EX cycles, no write_enable; ex_done on the final cycle -> WB, err=0.
- Opcode 0xD -> err=1, instr_ready=0; opcode 0xF -> halted=1; both sticky until reset_n low.
- reset_n asserted mid-WAIT_MEM -> outputs at reset values immediately, mem_req=0, next instruction accepted normally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction controller: opcodes, state encoding, default masks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ctrl_pkg;

    // Opcode map of the RISC microcontroller (4-bit opcode space)
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_DIV   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_SHF   = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_BEQ   = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Default opcode classification masks (bit i describes opcode i)
    localparam logic [15:0] DEF_NOWB_MASK    = 16'h8E00;
    localparam logic [15:0] DEF_MULTI_MASK   = 16'h000C;
    localparam logic [15:0] DEF_ILLEGAL_MASK = 16'h7000;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_WAIT_EX  = 3'd2,
        S_WAIT_MEM = 3'd3,
        S_WB       = 3'd4,
        S_HALT     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

endpackage

// File: rtl/control_fsm_if.sv
// Handshake bundle between the controller and fetch stage / execute unit / memory / register file.
// Latency: n/a (wires only).
// Backpressure: instr_valid/instr_ready on fetch; ex_start/ex_done and mem_req/mem_ack on the units.
// Ports: master = controller side, slave = datapath/environment side.
interface control_fsm_if #(
    parameter int OPW = 4,
    parameter int RAW = 3
);
    logic           instr_valid;
    logic           instr_ready;
    logic [OPW-1:0] opcode;
    logic [RAW-1:0] rd;
    logic           ex_start;
    logic           ex_done;
    logic           mem_req;
    logic           mem_ack;
    logic           write_enable;
    logic [RAW-1:0] wb_addr;
    logic           pc_en;
    logic           halted;
    logic           err;

    modport master (
        input  instr_valid, opcode, rd, ex_done, mem_ack,
        output instr_ready, ex_start, mem_req, write_enable, wb_addr, pc_en, halted, err
    );

    modport slave (
        output instr_valid, opcode, rd, ex_done, mem_ack,
        input  instr_ready, ex_start, mem_req, write_enable, wb_addr, pc_en, halted, err
    );
endinterface

// File: rtl/control_fsm_wait_timer.sv
// Execute-wait timer: synchronous clear, count-enable, flags the last allowed wait cycle.
// Latency: expired is combinational from the count register.
// Backpressure: none.
// Ports: clk, reset_n (async active-low), clear (priority), enable, expired.
module wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Count 0 is the first wait cycle, so MAX_WAIT-1 is the last one.
    assign expired = (count_q == W'(MAX_WAIT - 1));

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction controller: decode, execute/memory wait, write-back, halt and error traps.
// Latency: simple op accept N -> WB N+2 -> ready N+3; MUL/DIV WB one cycle after ex_done; LOAD/STORE one after mem_ack.
// Backpressure: instr_ready high only in FETCH; holds in WAIT_EX/WAIT_MEM until the unit answers.
// Ports: clk, reset_n, bus (control_fsm_if.master). All outputs are Moore outputs of the state register.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int              OPW          = 4,
    parameter int              RAW          = 3,
    parameter logic [2**OPW-1:0] NOWB_MASK    = DEF_NOWB_MASK,
    parameter logic [2**OPW-1:0] MULTI_MASK   = DEF_MULTI_MASK,
    parameter logic [2**OPW-1:0] ILLEGAL_MASK = DEF_ILLEGAL_MASK,
    parameter int              MAX_WAIT     = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    control_fsm_if.master bus
);
    localparam logic [OPW-1:0] HALT_OP  = OPW'(OP_HALT);
    localparam logic [OPW-1:0] LOAD_OP  = OPW'(OP_LOAD);
    localparam logic [OPW-1:0] STORE_OP = OPW'(OP_STORE);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q;
    logic [RAW-1:0] rd_q;
    logic           ex_expired;
    logic           dec_illegal, dec_halt, dec_multi, dec_mem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && bus.instr_valid) begin
                op_q <= bus.opcode;
                rd_q <= bus.rd;
            end
        end
    end

    // Timer runs only while waiting on the execute unit; any other state holds it at zero,
    // so the first WAIT_EX cycle always starts from a clean count.
    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q != S_WAIT_EX),
        .enable  (state_q == S_WAIT_EX),
        .expired (ex_expired)
    );

    // Decode classification in priority order: illegal, halt, multi-cycle, memory.
    assign dec_illegal = ILLEGAL_MASK[op_q];
    assign dec_halt    = !dec_illegal && (op_q == HALT_OP);
    assign dec_multi   = !dec_illegal && !dec_halt && MULTI_MASK[op_q];
    assign dec_mem     = !dec_illegal && !dec_halt && !dec_multi &&
                         ((op_q == LOAD_OP) || (op_q == STORE_OP));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.instr_valid) state_d = S_DECODE;
            S_DECODE: begin
                if (dec_illegal)    state_d = S_ERR;
                else if (dec_halt)  state_d = S_HALT;
                else if (dec_multi) state_d = S_WAIT_EX;
                else if (dec_mem)   state_d = S_WAIT_MEM;
                else                state_d = S_WB;
            end
            // A late ex_done on the final wait cycle still completes normally.
            S_WAIT_EX: begin
                if (bus.ex_done)     state_d = S_WB;
                else if (ex_expired) state_d = S_ERR;
            end
            S_WAIT_MEM: if (bus.mem_ack) state_d = S_WB;
            S_WB:       state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            S_ERR:      state_d = S_ERR;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.instr_ready  = 1'b0;
        bus.ex_start     = 1'b0;
        bus.mem_req      = 1'b0;
        bus.write_enable = 1'b0;
        bus.wb_addr      = '0;
        bus.pc_en        = 1'b0;
        bus.halted       = 1'b0;
        bus.err          = 1'b0;
        case (state_q)
            S_FETCH:    bus.instr_ready = 1'b1;
            S_DECODE:   bus.ex_start    = dec_multi;
            S_WAIT_MEM: bus.mem_req     = 1'b1;
            S_WB: begin
                bus.pc_en        = 1'b1;
                bus.write_enable = !NOWB_MASK[op_q];
                bus.wb_addr      = rd_q;
            end
            S_HALT:     bus.halted = 1'b1;
            S_ERR:      bus.err    = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    control_fsm_if #(.OPW(4), .RAW(3)) bus ();
    control_fsm_if #(.OPW(4), .RAW(3)) bus8 ();

    control_fsm u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    control_fsm #(.MAX_WAIT(8)) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Present one instruction to u_dut in FETCH; returns in the DECODE cycle.
    task automatic issue(input logic [3:0] op, input logic [2:0] r);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        bus.rd          = r;
        chk1("issue_ready", bus.instr_ready, 1'b1);
        tick();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.instr_valid = 1'b0;  bus.opcode = '0;  bus.rd = '0;
        bus.ex_done = 1'b0;      bus.mem_ack = 1'b0;
        bus8.instr_valid = 1'b0; bus8.opcode = '0; bus8.rd = '0;
        bus8.ex_done = 1'b0;     bus8.mem_ack = 1'b0;

        // Reset state
        tick();
        chk1("rst_ready", bus.instr_ready, 1'b1);
        chk1("rst_we", bus.write_enable, 1'b0);
        chk1("rst_pc_en", bus.pc_en, 1'b0);
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_ex_start", bus.ex_start, 1'b0);
        chk1("rst_halted", bus.halted, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chka("rst_wb_addr", bus.wb_addr, 3'd0);
        tick();
        reset_n = 1'b1;

        // ADD rd=5: WB at N+2, ready again at N+3
        issue(4'h0, 3'd5);
        chk1("add_dec_we", bus.write_enable, 1'b0);
        chk1("add_dec_pc", bus.pc_en, 1'b0);
        chk1("add_dec_ready", bus.instr_ready, 1'b0);
        tick();
        chk1("add_wb_we", bus.write_enable, 1'b1);
        chka("add_wb_addr", bus.wb_addr, 3'd5);
        chk1("add_wb_pc", bus.pc_en, 1'b1);
        chk1("add_wb_ready", bus.instr_ready, 1'b0);
        tick();
        chk1("add_n3_ready", bus.instr_ready, 1'b1);
        chk1("add_n3_we", bus.write_enable, 1'b0);
        chk1("add_n3_pc", bus.pc_en, 1'b0);

        // STORE rd=3: four mem_req cycles without ack, then ack cycle, then WB without write
        issue(4'h9, 3'd3);
        chk1("st_dec_mem_req", bus.mem_req, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk1("st_wait_mem_req", bus.mem_req, 1'b1);
            chk1("st_wait_pc", bus.pc_en, 1'b0);
            tick();
        end
        bus.mem_ack = 1'b1;
        chk1("st_ack_mem_req", bus.mem_req, 1'b1);
        tick();
        bus.mem_ack = 1'b0;
        chk1("st_wb_we", bus.write_enable, 1'b0);
        chk1("st_wb_pc", bus.pc_en, 1'b1);
        chk1("st_wb_mem_req", bus.mem_req, 1'b0);
        tick();
        chk1("st_done_ready", bus.instr_ready, 1'b1);

        // DIV rd=2: ex_start in DECODE only; ex_done in DECODE ignored; ex_done 10 cycles later -> WB
        issue(4'h3, 3'd2);
        chk1("div_ex_start", bus.ex_start, 1'b1);
        bus.ex_done = 1'b1;
        tick();
        bus.ex_done = 1'b0;
        chk1("div_dec_done_ignored", bus.pc_en, 1'b0);
        for (int i = 0; i < 9; i++) begin
            chk1("div_wait_ex_start", bus.ex_start, 1'b0);
            chk1("div_wait_we", bus.write_enable, 1'b0);
            tick();
        end
        bus.ex_done = 1'b1;
        chk1("div_done_we", bus.write_enable, 1'b0);
        tick();
        bus.ex_done = 1'b0;
        chk1("div_wb_we", bus.write_enable, 1'b1);
        chka("div_wb_addr", bus.wb_addr, 3'd2);
        chk1("div_wb_pc", bus.pc_en, 1'b1);
        tick();

        // MUL on MAX_WAIT=8 instance, ex_done never: 8 WAIT_EX cycles then ERR
        bus8.instr_valid = 1'b1; bus8.opcode = 4'h2; bus8.rd = 3'd1;
        tick();
        bus8.instr_valid = 1'b0;
        chk1("mul_to_ex_start", bus8.ex_start, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk1("mul_to_wait_err", bus8.err, 1'b0);
            chk1("mul_to_wait_we", bus8.write_enable, 1'b0);
            chk1("mul_to_wait_pc", bus8.pc_en, 1'b0);
            tick();
        end
        chk1("mul_to_err", bus8.err, 1'b1);
        chk1("mul_to_err_ready", bus8.instr_ready, 1'b0);
        chk1("mul_to_err_we", bus8.write_enable, 1'b0);
        tick();
        chk1("mul_to_err_sticky", bus8.err, 1'b1);
        pulse_reset();
        chk1("mul_rst_err", bus8.err, 1'b0);
        chk1("mul_rst_ready", bus8.instr_ready, 1'b1);

        // MUL with ex_done on the last allowed wait cycle -> WB, no error
        bus8.instr_valid = 1'b1; bus8.opcode = 4'h2; bus8.rd = 3'd4;
        tick();
        bus8.instr_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        bus8.ex_done = 1'b1;
        chk1("mul_late_err", bus8.err, 1'b0);
        tick();
        bus8.ex_done = 1'b0;
        chk1("mul_late_wb_we", bus8.write_enable, 1'b1);
        chka("mul_late_wb_addr", bus8.wb_addr, 3'd4);
        chk1("mul_late_err_wb", bus8.err, 1'b0);
        tick();
        chk1("mul_late_ready", bus8.instr_ready, 1'b1);

        // Illegal opcode 0xD -> sticky ERR
        issue(4'hD, 3'd0);
        tick();
        chk1("ill_err", bus.err, 1'b1);
        chk1("ill_ready", bus.instr_ready, 1'b0);
        bus.instr_valid = 1'b1; bus.opcode = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("ill_sticky_err", bus.err, 1'b1);
            chk1("ill_sticky_ready", bus.instr_ready, 1'b0);
            chk1("ill_sticky_we", bus.write_enable, 1'b0);
        end
        bus.instr_valid = 1'b0;
        pulse_reset();
        chk1("ill_rst_err", bus.err, 1'b0);
        chk1("ill_rst_ready", bus.instr_ready, 1'b1);

        // HALT -> sticky halted
        issue(4'hF, 3'd0);
        tick();
        chk1("halt_halted", bus.halted, 1'b1);
        chk1("halt_ready", bus.instr_ready, 1'b0);
        chk1("halt_err", bus.err, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("halt_sticky", bus.halted, 1'b1);
            chk1("halt_sticky_pc", bus.pc_en, 1'b0);
        end
        pulse_reset();
        chk1("halt_rst", bus.halted, 1'b0);

        // Reset in the middle of a LOAD wait, then a normal ADD
        issue(4'h8, 3'd6);
        tick();
        chk1("ld_mem_req", bus.mem_req, 1'b1);
        tick();
        chk1("ld_mem_req2", bus.mem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("ld_rst_mem_req", bus.mem_req, 1'b0);
        chk1("ld_rst_ready", bus.instr_ready, 1'b1);
        chk1("ld_rst_we", bus.write_enable, 1'b0);
        chk1("ld_rst_pc", bus.pc_en, 1'b0);
        chka("ld_rst_wb_addr", bus.wb_addr, 3'd0);
        tick();
        reset_n = 1'b1;
        issue(4'h0, 3'd7);
        tick();
        chk1("post_rst_we", bus.write_enable, 1'b1);
        chka("post_rst_wb_addr", bus.wb_addr, 3'd7);
        chk1("post_rst_pc", bus.pc_en, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
